// File: rtl/key_debouncer.sv
// key_debouncer
//
// Conditions the raw push-button keys before they reach the synchroniser /
// edge-detector path that drives mode, inc and nxt. Each active-low,
// asynchronous, bouncing key is synchronised, debounced by a per-key state
// machine, and turned into a clean level plus one-cycle press and release
// pulses. While a key is held, press pulses can auto-repeat so an edit-mode
// increment can scroll.
//
// Ports:
//   clk           system clock (CLOCK_50)
//   reset_n       asynchronous active-low reset
//   key_n[N]      raw KEY pins, active-low, asynchronous to clk
//   pressed[N]    debounced key level, active-high
//   press_pulse   one-cycle pulse on an accepted press and on each auto-repeat
//   release_pulse one-cycle pulse on an accepted release
//
// All outputs are registered, so there is no combinational path from key_n.

module key_debouncer #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse
);

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_W   = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
  localparam logic [RP_W-1:0] RP_SAT     = '1;

  localparam logic [1:0] ST_UP    = 2'd0;
  localparam logic [1:0] ST_DB_DN = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;
  localparam logic [1:0] ST_DB_UP = 2'd3;

  logic [N-1:0]      sync_q1;
  logic [N-1:0]      sync_q2;
  logic [1:0]        state [N];
  logic [DB_W-1:0]   db    [N];
  logic [RP_W-1:0]   rp    [N];
  logic [N-1:0]      first;

  logic [N-1:0]      rep_fire;
  logic [RP_W-1:0]   rp_step    [N];
  logic [N-1:0]      first_step;

  // Two-flop synchroniser; the key is inverted on entry so a pressed key
  // reads as 1 from here on, and reset leaves every key looking released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ~key_n;
      sync_q2 <= sync_q1;
    end
  end

  // One held-cycle step of the auto-repeat timer for each key: decides
  // whether this cycle emits a repeat pulse and what rp/first become.
  // The first repeat waits REPEAT_DELAY, later ones REPEAT_RATE. With
  // repeat disabled the counter just saturates and never fires.
  always_comb begin
    rep_fire   = '0;
    first_step = first;
    for (int i = 0; i < N; i++) begin
      rp_step[i] = rp[i] + RP_W'(1);
      if (REPEAT_EN != 0) begin
        if (first[i] && (rp[i] == DELAY_LAST)) begin
          rep_fire[i]   = 1'b1;
          rp_step[i]    = '0;
          first_step[i] = 1'b0;
        end else if (!first[i] && (rp[i] == RATE_LAST)) begin
          rep_fire[i] = 1'b1;
          rp_step[i]  = '0;
        end
      end else if (rp[i] == RP_SAT) begin
        rp_step[i] = rp[i];
      end
    end
  end

  // Per-key debounce FSM. A change is only accepted after DEBOUNCE_CYCLES
  // consecutive agreeing samples; any disagreement sends the key back to its
  // stable state. A short release bounce while held parks in DB_UP with rp
  // frozen; the edge that returns to HELD counts as a held cycle again, so
  // the next repeat is delayed by exactly the cycles spent in DB_UP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      first         <= '0;
      for (int i = 0; i < N; i++) begin
        state[i] <= ST_UP;
        db[i]    <= '0;
        rp[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        case (state[i])
          ST_UP: begin
            if (sync_q2[i]) begin
              state[i] <= ST_DB_DN;
              db[i]    <= DB_W'(1);
            end
          end
          ST_DB_DN: begin
            if (!sync_q2[i]) begin
              state[i] <= ST_UP;
              db[i]    <= '0;
            end else if (db[i] == DB_LAST) begin
              state[i]       <= ST_HELD;
              rp[i]          <= '0;
              first[i]       <= 1'b1;
              pressed[i]     <= 1'b1;
              press_pulse[i] <= 1'b1;
            end else begin
              db[i] <= db[i] + DB_W'(1);
            end
          end
          ST_HELD: begin
            if (!sync_q2[i]) begin
              state[i] <= ST_DB_UP;
              db[i]    <= DB_W'(1);
            end else begin
              rp[i]          <= rp_step[i];
              first[i]       <= first_step[i];
              press_pulse[i] <= rep_fire[i];
            end
          end
          default: begin
            if (sync_q2[i]) begin
              state[i]       <= ST_HELD;
              rp[i]          <= rp_step[i];
              first[i]       <= first_step[i];
              press_pulse[i] <= rep_fire[i];
            end else if (db[i] == DB_LAST) begin
              state[i]         <= ST_UP;
              db[i]            <= '0;
              pressed[i]       <= 1'b0;
              release_pulse[i] <= 1'b1;
            end else begin
              db[i] <= db[i] + DB_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
